// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier datapath: FSM state encoding,
// default operand widths and a ceil-div helper used to size digit counters.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int MY_W = 9;
  localparam int MC_W = 16;

  function automatic int ceilDiv(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/operand_digit_shifter.sv
// Multiplier-operand shifter: loads an operand, then presents it LSB-first as
// DIGIT-bit digits, one per STEP, flagging the final digit and pulsing DONE.
module operand_digit_shifter
  import mult_pkg::*;
#(
  parameter int WIDTH      = MY_W,
  parameter int DIGIT      = 1,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic                                         CLK,
  input  logic                                         RST,
  input  logic [WIDTH-1:0]                             IN_MY,
  input  logic                                         LD_VALID,
  output logic                                         LD_READY,
  input  logic                                         STEP,
  input  logic                                         ABORT,
  output logic [DIGIT-1:0]                             DIGIT_OUT,
  output logic                                         DIGIT_VALID,
  output logic                                         LAST,
  output logic [$clog2(ceilDiv(WIDTH, DIGIT) + 1)-1:0] STEPS_LEFT,
  output logic                                         DONE
);

  localparam int N   = ceilDiv(WIDTH, DIGIT);
  localparam int MYW = N * DIGIT;
  localparam int CW  = $clog2(N + 1);

  if (!(DIGIT == 1 || DIGIT == 2) || WIDTH < 2) begin : gParamCheck
    $fatal(1, "operand_digit_shifter: DIGIT must be 1 or 2 and WIDTH at least 2");
  end

  state_t         r_state;
  state_t         w_stateNext;
  logic [MYW-1:0] r_my;
  logic [MYW-1:0] w_myNext;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cntNext;
  logic           w_run;
  logic           w_upperZero;
  logic           w_last;

  assign w_run       = (r_state == RUN);
  // Shift rather than slice so the single-digit case (MYW == DIGIT) stays legal.
  assign w_upperZero = ((r_my >> DIGIT) == '0);
  assign w_last      = w_run && ((r_cnt == CW'(1)) || (EARLY_EXIT && w_upperZero));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_my    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_my    <= w_myNext;
      r_cnt   <= w_cntNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_myNext    = r_my;
    w_cntNext   = r_cnt;
    case (r_state)
      IDLE: begin
        if (LD_VALID) begin
          w_stateNext            = RUN;
          w_myNext               = '0;
          w_myNext[WIDTH-1:0]    = IN_MY;
          w_cntNext              = CW'(N);
        end
      end
      RUN: begin
        // Abort wins over a simultaneous step and discards the operand.
        if (ABORT) begin
          w_stateNext = FIN;
          w_myNext    = '0;
        end else if (STEP) begin
          if (w_last) begin
            w_stateNext = FIN;
          end else begin
            w_myNext  = r_my >> DIGIT;
            w_cntNext = r_cnt - CW'(1);
          end
        end
      end
      FIN: begin
        w_stateNext = IDLE;
        w_myNext    = '0;
        w_cntNext   = '0;
      end
      default: begin
        w_stateNext = IDLE;
        w_myNext    = '0;
        w_cntNext   = '0;
      end
    endcase
  end

  assign LD_READY    = (r_state == IDLE);
  assign DIGIT_VALID = w_run;
  assign DIGIT_OUT   = r_my[DIGIT-1:0];
  assign LAST        = w_last;
  assign STEPS_LEFT  = w_run ? r_cnt : '0;
  assign DONE        = (r_state == FIN);

endmodule

// File: tb/tb_operand_digit_shifter.sv
// Self-checking bench: three shifter variants (radix-2, radix-4, radix-2 with early
// exit) share one stimulus stream and are compared against a digit-index model.
module tb_operand_digit_shifter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [8:0] inMy = '0;
  logic       ldValid = 1'b0;
  logic       step = 1'b0;
  logic       abort = 1'b0;

  logic [2:0] ldReadyV;
  logic [2:0] digitValidV;
  logic [2:0] lastV;
  logic [2:0] doneV;
  logic [0:0] digitOut0;
  logic [1:0] digitOut1;
  logic [0:0] digitOut2;
  logic [3:0] steps0;
  logic [2:0] steps1;
  logic [3:0] steps2;

  int nCompared = 0;
  int nFailed = 0;

  int mState[3];
  int mOp[3];
  int mPos[3];

  typedef struct {
    bit ld;
    bit st;
    int dig0;
    bit last0;
    int steps0;
    bit done0;
    int dig1;
    bit last1;
    int steps1;
    bit done1;
  } vec_t;

  vec_t vecs[12];

  always #5 CLK = ~CLK;

  operand_digit_shifter #(.WIDTH(9), .DIGIT(1), .EARLY_EXIT(1'b0)) u0 (
    .CLK(CLK), .RST(RST), .IN_MY(inMy), .LD_VALID(ldValid), .LD_READY(ldReadyV[0]),
    .STEP(step), .ABORT(abort), .DIGIT_OUT(digitOut0), .DIGIT_VALID(digitValidV[0]),
    .LAST(lastV[0]), .STEPS_LEFT(steps0), .DONE(doneV[0])
  );

  operand_digit_shifter #(.WIDTH(9), .DIGIT(2), .EARLY_EXIT(1'b0)) u1 (
    .CLK(CLK), .RST(RST), .IN_MY(inMy), .LD_VALID(ldValid), .LD_READY(ldReadyV[1]),
    .STEP(step), .ABORT(abort), .DIGIT_OUT(digitOut1), .DIGIT_VALID(digitValidV[1]),
    .LAST(lastV[1]), .STEPS_LEFT(steps1), .DONE(doneV[1])
  );

  operand_digit_shifter #(.WIDTH(9), .DIGIT(1), .EARLY_EXIT(1'b1)) u2 (
    .CLK(CLK), .RST(RST), .IN_MY(inMy), .LD_VALID(ldValid), .LD_READY(ldReadyV[2]),
    .STEP(step), .ABORT(abort), .DIGIT_OUT(digitOut2), .DIGIT_VALID(digitValidV[2]),
    .LAST(lastV[2]), .STEPS_LEFT(steps2), .DONE(doneV[2])
  );

  function automatic int dOf(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  function automatic bit eeOf(input int i);
    return (i == 2);
  endfunction

  function automatic int nOf(input int i);
    return (9 + dOf(i) - 1) / dOf(i);
  endfunction

  // Model: the operand is kept whole; the current digit is picked by index.
  function automatic int expDigit(input int i);
    return (mOp[i] >> (mPos[i] * dOf(i))) & ((1 << dOf(i)) - 1);
  endfunction

  function automatic int expLast(input int i);
    if (mState[i] != 1) return 0;
    if (mPos[i] == nOf(i) - 1) return 1;
    if (eeOf(i) && ((mOp[i] >> ((mPos[i] + 1) * dOf(i))) == 0)) return 1;
    return 0;
  endfunction

  function automatic int actDigit(input int i);
    case (i)
      0: return int'(digitOut0);
      1: return int'(digitOut1);
      default: return int'(digitOut2);
    endcase
  endfunction

  function automatic int actSteps(input int i);
    case (i)
      0: return int'(steps0);
      1: return int'(steps1);
      default: return int'(steps2);
    endcase
  endfunction

  task automatic checkField(input string name, input int i, input int act, input int exp);
    nCompared++;
    if (act != exp) begin
      nFailed++;
      $display("[TB] FAIL %s u%0d at %0t: got %0d expected %0d", name, i, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit ld, input int val, input bit st, input bit ab);
    ldValid = ld;
    inMy    = 9'(val);
    step    = st;
    abort   = ab;
    @(negedge CLK);
  endtask

  task automatic checkOutput();
    for (int i = 0; i < 3; i++) begin
      checkField("ldReady", i, int'(ldReadyV[i]), (mState[i] == 0) ? 1 : 0);
      checkField("digitValid", i, int'(digitValidV[i]), (mState[i] == 1) ? 1 : 0);
      checkField("digitOut", i, actDigit(i), expDigit(i));
      checkField("last", i, int'(lastV[i]), expLast(i));
      checkField("stepsLeft", i, actSteps(i), (mState[i] == 1) ? nOf(i) - mPos[i] : 0);
      checkField("done", i, int'(doneV[i]), (mState[i] == 2) ? 1 : 0);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < 3; i++) begin
      mState[i] = 0;
      mOp[i]    = 0;
      mPos[i]   = 0;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    for (int i = 0; i < 3; i++) begin
      if (RST) begin
        mState[i] = 0;
        mOp[i]    = 0;
        mPos[i]   = 0;
      end else begin
        case (mState[i])
          0: if (ldValid) begin
            mState[i] = 1;
            mOp[i]    = int'(inMy);
            mPos[i]   = 0;
          end
          1: if (abort) begin
            mState[i] = 2;
            mOp[i]    = 0;
          end else if (step) begin
            if (expLast(i) != 0) mState[i] = 2;
            else mPos[i]++;
          end
          default: begin
            mState[i] = 0;
            mOp[i]    = 0;
            mPos[i]   = 0;
          end
        endcase
      end
    end
    #1;
  endtask

  task automatic cycle(input bit ld, input int val, input bit st, input bit ab);
    applyStimulus(ld, val, st, ab);
    checkOutput();
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;

    // Expected digits of 9'h1A5: radix-2 1,0,1,0,0,1,0,1,1 and radix-4 1,1,2,2,1.
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 1, 0, 9, 0, 1, 0, 5, 0};
    vecs[2]  = '{0, 1, 0, 0, 8, 0, 1, 0, 4, 0};
    vecs[3]  = '{0, 1, 1, 0, 7, 0, 2, 0, 3, 0};
    vecs[4]  = '{0, 1, 0, 0, 6, 0, 2, 0, 2, 0};
    vecs[5]  = '{0, 1, 0, 0, 5, 0, 1, 1, 1, 0};
    vecs[6]  = '{0, 1, 1, 0, 4, 0, 1, 0, 0, 1};
    vecs[7]  = '{0, 1, 0, 0, 3, 0, 0, 0, 0, 0};
    vecs[8]  = '{0, 1, 1, 0, 2, 0, 0, 0, 0, 0};
    vecs[9]  = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    vecs[10] = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 0};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    resetModel();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    $display("[TB] table: 9'h1A5 with STEP held high");
    for (int r = 0; r < 12; r++) begin
      applyStimulus(vecs[r].ld, 'h1A5, vecs[r].st, 1'b0);
      checkOutput();
      checkField("tblDigit", 0, int'(digitOut0), vecs[r].dig0);
      checkField("tblLast", 0, int'(lastV[0]), int'(vecs[r].last0));
      checkField("tblSteps", 0, int'(steps0), vecs[r].steps0);
      checkField("tblDone", 0, int'(doneV[0]), int'(vecs[r].done0));
      checkField("tblDigit", 1, int'(digitOut1), vecs[r].dig1);
      checkField("tblLast", 1, int'(lastV[1]), int'(vecs[r].last1));
      checkField("tblSteps", 1, int'(steps1), vecs[r].steps1);
      checkField("tblDone", 1, int'(doneV[1]), int'(vecs[r].done1));
      tick();
    end

    $display("[TB] early exit: 9'h005 then 9'h000");
    cycle(1'b1, 'h005, 1'b0, 1'b0);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b0, 0, 1'b1, 1'b0);
      if (digitValidV[2]) cnt++;
      checkOutput();
      tick();
    end
    checkField("eeDigitCount", 2, cnt, 3);
    cycle(1'b1, 'h000, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    checkOutput();
    checkField("eeZeroLast", 2, int'(lastV[2]), 1);
    checkField("eeZeroLast", 0, int'(lastV[0]), 0);
    tick();
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);

    $display("[TB] stall, load during RUN, abort with step");
    cycle(1'b1, 'h0B6, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    applyStimulus(1'b1, 'h0FF, 1'b0, 1'b0);
    checkOutput();
    checkField("readyInRun", 0, int'(ldReadyV[0]), 0);
    tick();
    cycle(1'b1, 'h0FF, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b1);
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    checkOutput();
    for (int i = 0; i < 3; i++) begin
      checkField("abortDone", i, int'(doneV[i]), 1);
      checkField("abortCleared", i, actDigit(i), 0);
    end
    tick();
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    checkOutput();
    checkField("abortIdleReady", 1, int'(ldReadyV[1]), 1);
    tick();

    $display("[TB] asynchronous reset mid-RUN");
    cycle(1'b1, 'h1FF, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    resetModel();
    for (int i = 0; i < 3; i++) begin
      checkField("rstReady", i, int'(ldReadyV[i]), 1);
      checkField("rstValid", i, int'(digitValidV[i]), 0);
      checkField("rstDigit", i, actDigit(i), 0);
      checkField("rstLast", i, int'(lastV[i]), 0);
      checkField("rstSteps", i, actSteps(i), 0);
      checkField("rstDone", i, int'(doneV[i]), 0);
    end
    cycle(1'b0, 0, 1'b1, 1'b0);
    RST = 1'b0;
    cycle(1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, 'h0C3, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) cycle(1'b0, 0, 1'b1, 1'b0);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 500; k++) begin
      int v;
      v = int'($urandom_range(0, 511));
      if ($urandom_range(0, 2) == 0) v = v & 'h00F;
      cycle(($urandom_range(0, 3) == 0), v, ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 19) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
